// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared counter width, saturation limit and lock FSM encoding for sync timing detection.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

  // Default width of every timing counter and measurement.
  localparam int CNT_W_DEF = 11;

  // Value at which an 11-bit timing counter stops counting (no sync seen).
  localparam int unsigned CNT_SAT_DEF = (32'd1 << CNT_W_DEF) - 32'd1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } det_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: two-flop sample of one sync input, polarity normalised, with assert/deassert edge pulses.
// Latency: the active level shows on 'active' one clock after the pin; edge pulses are combinational from the two flops.
// Backpressure: none, free-running sampler.
// Ports: pixel_clk/rst_n clock and async active-low reset; sync_in raw pin;
//        active = normalised level (1 = sync asserted); assert_pulse / deassert_pulse = one-cycle edges.
module vga_sync_edge #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic pixel_clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic active,
  output logic assert_pulse,
  output logic deassert_pulse
);

  // s/d hold the normalised level, so reset to 0 means "sync inactive".
  logic s;
  logic d;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 1'b0;
      d <= 1'b0;
    end else begin
      s <= (sync_in == SYNC_POL);
      d <= s;
    end
  end

  assign active         = s;
  assign assert_pulse   = s & ~d;
  assign deassert_pulse = ~s & d;

endmodule

// File: rtl/vga_timing_detect.sv
// vga_timing_detect: measures incoming hsync/vsync timing, locks when stable, reports pixel/line position.
// Latency: every sync-edge driven update lands 2 pixel_clk after the edge reaches the pin.
// Backpressure: none; the sync source is free-running and never stalled.
// Ports: pixel_clk, rst_n (async active-low); hsync_in/vsync_in raw syncs;
//        line_len/hsync_len/frame_lines/vsync_lines measurements; h_pos/v_pos position (valid while locked);
//        frame_start pulse per vsync edge; locked status; lock_err pulse on lock loss.
module vga_timing_detect
  import vga_timing_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] hsync_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic [CNT_W-1:0] vsync_lines,
  output logic [CNT_W-1:0] h_pos,
  output logic [CNT_W-1:0] v_pos,
  output logic             frame_start,
  output logic             locked,
  output logic             lock_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  // The candidate frame itself counts as the first of the LOCK_FRAMES agreeing frames.
  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_FRAMES - 1);

  logic h_act, h_rise, h_fall;
  logic v_act, v_rise, v_fall;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hsync (
    .pixel_clk      (pixel_clk),
    .rst_n          (rst_n),
    .sync_in        (hsync_in),
    .active         (h_act),
    .assert_pulse   (h_rise),
    .deassert_pulse (h_fall)
  );

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vsync (
    .pixel_clk      (pixel_clk),
    .rst_n          (rst_n),
    .sync_in        (vsync_in),
    .active         (v_act),
    .assert_pulse   (v_rise),
    .deassert_pulse (v_fall)
  );

  // ---------------- measurement datapath ----------------
  logic [CNT_W-1:0] h_cnt, v_cnt, hw_cnt, vw_cnt;
  logic [CNT_W-1:0] meas_line;
  logic             h_sat, v_sat;

  assign meas_line = h_cnt + ONE;
  assign h_sat     = (h_cnt == CNT_MAX);
  assign v_sat     = (v_cnt == CNT_MAX);
  assign h_pos     = h_cnt;
  assign v_pos     = v_cnt;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hw_cnt      <= '0;
      vw_cnt      <= '0;
      line_len    <= '0;
      hsync_len   <= '0;
      frame_lines <= '0;
      vsync_lines <= '0;
      frame_start <= 1'b0;
    end else begin
      if (h_rise) begin
        h_cnt    <= '0;
        line_len <= meas_line;
      end else if (!h_sat) begin
        h_cnt <= h_cnt + ONE;
      end

      if (h_rise) begin
        hw_cnt <= ONE;
      end else if (h_act && hw_cnt != CNT_MAX) begin
        hw_cnt <= hw_cnt + ONE;
      end
      if (h_fall) begin
        hsync_len <= hw_cnt;
      end

      // A line starting in the same cycle as vsync belongs to the new frame.
      if (v_rise) begin
        frame_lines <= v_cnt;
        v_cnt       <= h_rise ? ONE : '0;
      end else if (h_rise && !v_sat) begin
        v_cnt <= v_cnt + ONE;
      end

      if (v_rise) begin
        vw_cnt <= h_rise ? ONE : '0;
      end else if (v_act && h_rise && vw_cnt != CNT_MAX) begin
        vw_cnt <= vw_cnt + ONE;
      end
      if (v_fall) begin
        vsync_lines <= vw_cnt;
      end

      frame_start <= v_rise;
    end
  end

  // ---------------- lock FSM ----------------
  det_state_t       state, state_nxt;
  logic [CNT_W-1:0] cand_line, cand_line_nxt;
  logic [CNT_W-1:0] cand_frame, cand_frame_nxt;
  logic [7:0]       match_cnt, match_nxt;
  logic             unstable, unstable_nxt;
  logic             h_seen, h_seen_nxt;    // at least one hsync edge since (re)start
  logic             line_ok, line_ok_nxt;  // at least one complete line measured
  logic             locked_nxt, lock_err_nxt;
  logic             line_bad;
  logic [CNT_W-1:0] load_line;

  assign line_bad  = h_rise && (meas_line != cand_line);
  // Candidate line length must include a measurement landing in this same cycle.
  assign load_line = h_rise ? meas_line : line_len;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SEARCH;
      cand_line  <= '0;
      cand_frame <= '0;
      match_cnt  <= '0;
      unstable   <= 1'b0;
      h_seen     <= 1'b0;
      line_ok    <= 1'b0;
      locked     <= 1'b0;
      lock_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand_line  <= cand_line_nxt;
      cand_frame <= cand_frame_nxt;
      match_cnt  <= match_nxt;
      unstable   <= unstable_nxt;
      h_seen     <= h_seen_nxt;
      line_ok    <= line_ok_nxt;
      locked     <= locked_nxt;
      lock_err   <= lock_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cand_line_nxt  = cand_line;
    cand_frame_nxt = cand_frame;
    match_nxt      = match_cnt;
    unstable_nxt   = unstable;
    h_seen_nxt     = h_seen | h_rise;
    line_ok_nxt    = line_ok | (h_rise & h_seen);
    locked_nxt     = locked;
    lock_err_nxt   = 1'b0;

    case (state)
      ST_SEARCH: begin
        if (v_rise && line_ok) begin
          state_nxt      = ST_TRACK;
          cand_line_nxt  = load_line;
          cand_frame_nxt = v_cnt;
          match_nxt      = '0;
          unstable_nxt   = 1'b0;
        end
      end
      ST_TRACK: begin
        if (line_bad) begin
          unstable_nxt = 1'b1;
        end
        if (v_rise) begin
          // The line closing at this vsync is the last line of the old frame.
          unstable_nxt = 1'b0;
          if (!unstable && !line_bad && v_cnt == cand_frame) begin
            match_nxt = match_cnt + 8'd1;
            if (match_cnt + 8'd1 >= LOCK_TGT) begin
              state_nxt  = ST_LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            cand_line_nxt  = load_line;
            cand_frame_nxt = v_cnt;
            match_nxt      = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || (v_rise && v_cnt != cand_frame)) begin
          state_nxt    = ST_SEARCH;
          locked_nxt   = 1'b0;
          lock_err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_SEARCH;
    endcase

    // A saturated counter means the sync stopped; the next measurement is meaningless.
    if (h_sat || v_sat) begin
      state_nxt    = ST_SEARCH;
      locked_nxt   = 1'b0;
      lock_err_nxt = (state == ST_LOCKED);
    end
    if (h_sat) begin
      h_seen_nxt  = 1'b0;
      line_ok_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_detect.sv
module tb_vga_timing_detect;
  import vga_timing_pkg::*;

  localparam int W = 11;

  logic         pixel_clk = 1'b0;
  logic         rst_n;
  logic         hsync_in;
  logic         vsync_in;
  logic [W-1:0] line_len, hsync_len, frame_lines, vsync_lines, h_pos, v_pos;
  logic         frame_start, locked, lock_err;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  logic [W-1:0] fs_hpos, fs_vpos;
  logic [W-1:0] sat_exp;

  // active timing pattern: line length, hsync width, hsync start, lines per frame, vsync lines
  int cfg_len, cfg_hw, cfg_hoff, cfg_lines, cfg_vw;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_detect #(.CNT_W(W), .LOCK_FRAMES(2), .SYNC_POL(1'b0)) dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .line_len    (line_len),
    .hsync_len   (hsync_len),
    .frame_lines (frame_lines),
    .vsync_lines (vsync_lines),
    .h_pos       (h_pos),
    .v_pos       (v_pos),
    .frame_start (frame_start),
    .locked      (locked),
    .lock_err    (lock_err)
  );

  // One clock: sample outputs 1 time unit after the edge, then drive the next pin values.
  task automatic step(input logic hs, input logic vs);
    @(posedge pixel_clk);
    #1;
    if (lock_err === 1'b1) err_cnt++;
    if (frame_start === 1'b1) begin
      fs_hpos = h_pos;
      fs_vpos = v_pos;
    end
    hsync_in = hs;
    vsync_in = vs;
  endtask

  // Active-low syncs; long_line gets one extra inactive cycle at its end.
  task automatic drive_lines(input int l0, input int l1, input int long_line);
    for (int ln = l0; ln <= l1; ln++) begin
      int n;
      n = (ln == long_line) ? cfg_len + 1 : cfg_len;
      for (int h = 0; h < n; h++)
        step(!(h >= cfg_hoff && h < cfg_hoff + cfg_hw), !(ln < cfg_vw));
    end
  endtask

  task automatic drive_frames(input int n);
    for (int f = 0; f < n; f++) drive_lines(0, cfg_lines - 1, -1);
  endtask

  task automatic set_cfg(input int len, input int hw, input int hoff, input int lines, input int vw);
    cfg_len = len; cfg_hw = hw; cfg_hoff = hoff; cfg_lines = lines; cfg_vw = vw;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    #12;
    total++; if ({line_len, hsync_len, frame_lines, vsync_lines, h_pos, v_pos, frame_start, locked, lock_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got line_len=%0d hsync_len=%0d frame_lines=%0d vsync_lines=%0d h_pos=%0d v_pos=%0d fs=%b lk=%b err=%b, expected all 0",
        line_len, hsync_len, frame_lines, vsync_lines, h_pos, v_pos, frame_start, locked, lock_err); end
    do_reset();
  endtask

  task automatic test_basic();
    set_cfg(20, 3, 4, 10, 2);
    do_reset();
    fs_hpos = '1; fs_vpos = '1;
    drive_frames(2);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL basic_not_yet_locked: got %b expected 0", locked); end
    drive_frames(1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL basic_locked: got %b expected 1", locked); end
    total++; if (line_len !== 11'd20) begin bad++; $display("FAIL basic_line_len: got %0d expected 20", line_len); end
    total++; if (hsync_len !== 11'd3) begin bad++; $display("FAIL basic_hsync_len: got %0d expected 3", hsync_len); end
    total++; if (frame_lines !== 11'd10) begin bad++; $display("FAIL basic_frame_lines: got %0d expected 10", frame_lines); end
    total++; if (vsync_lines !== 11'd2) begin bad++; $display("FAIL basic_vsync_lines: got %0d expected 2", vsync_lines); end
    total++; if (fs_hpos !== 11'd16 || fs_vpos !== 11'd0) begin bad++; $display("FAIL basic_pos_at_frame_start: got h=%0d v=%0d expected h=16 v=0", fs_hpos, fs_vpos); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL basic_no_lock_err: got %0d pulses expected 0", err_cnt); end
  endtask

  task automatic test_vga640();
    set_cfg(743, 32, 656, 8, 5);
    do_reset();
    drive_frames(3);
    total++; if (line_len !== 11'd743) begin bad++; $display("FAIL vga_line_len: got %0d expected 743", line_len); end
    total++; if (hsync_len !== 11'd32) begin bad++; $display("FAIL vga_hsync_len: got %0d expected 32", hsync_len); end
    total++; if (frame_lines !== 11'd8) begin bad++; $display("FAIL vga_frame_lines: got %0d expected 8", frame_lines); end
    total++; if (vsync_lines !== 11'd5) begin bad++; $display("FAIL vga_vsync_lines: got %0d expected 5", vsync_lines); end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL vga_locked: got %b expected 1", locked); end
  endtask

  task automatic test_line_glitch();
    int e0;
    set_cfg(20, 3, 4, 10, 2);
    do_reset();
    drive_frames(3);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch_pre_locked: got %b expected 1", locked); end
    e0 = err_cnt;
    drive_lines(0, 9, 5);
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL glitch_lock_err: got %0d pulses expected %0d", err_cnt - e0, 1); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL glitch_unlocked: got %b expected 0", locked); end
    drive_frames(1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL glitch_still_searching: got %b expected 0", locked); end
    drive_frames(2);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL glitch_relocked: got %b expected 1", locked); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL glitch_single_err: got %0d pulses expected 1", err_cnt - e0); end
  endtask

  task automatic test_hsync_stop();
    int e0;
    e0 = err_cnt;
    repeat (1900) step(1'b1, 1'b1);
    total++; if (locked !== 1'b1 || err_cnt !== e0) begin bad++; $display("FAIL stop_early: got locked=%b errs=%0d expected locked=1 errs=0", locked, err_cnt - e0); end
    repeat (300) step(1'b1, 1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL stop_unlocked: got %b expected 0", locked); end
    total++; if (err_cnt !== e0 + 1) begin bad++; $display("FAIL stop_lock_err_once: got %0d pulses expected 1", err_cnt - e0); end
    total++; if (h_pos !== sat_exp) begin bad++; $display("FAIL stop_h_saturated: got %0d expected %0d", h_pos, sat_exp); end
    total++; if (line_len !== 11'd20 || hsync_len !== 11'd3 || frame_lines !== 11'd10 || vsync_lines !== 11'd2) begin
      bad++; $display("FAIL stop_hold: got %0d/%0d/%0d/%0d expected 20/3/10/2", line_len, hsync_len, frame_lines, vsync_lines); end
  endtask

  task automatic test_coincident();
    int e0;
    e0 = err_cnt;
    set_cfg(20, 3, 0, 10, 2);
    fs_hpos = '1; fs_vpos = '1;
    drive_frames(3);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL coinc_locked: got %b expected 1", locked); end
    total++; if (frame_lines !== 11'd10 || line_len !== 11'd20) begin bad++; $display("FAIL coinc_meas: got frame=%0d line=%0d expected 10/20", frame_lines, line_len); end
    total++; if (fs_vpos !== 11'd1 || fs_hpos !== 11'd0) begin bad++; $display("FAIL coinc_pos: got v=%0d h=%0d expected v=1 h=0", fs_vpos, fs_hpos); end
    total++; if (vsync_lines !== 11'd2) begin bad++; $display("FAIL coinc_vsync_lines: got %0d expected 2", vsync_lines); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL coinc_no_err: got %0d pulses expected 0", err_cnt - e0); end
  endtask

  task automatic test_reset_midframe();
    drive_lines(0, 4, -1);
    #3 rst_n = 1'b0;
    #1;
    total++; if ({line_len, hsync_len, frame_lines, vsync_lines, h_pos, v_pos, frame_start, locked, lock_err} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got line_len=%0d frame_lines=%0d h_pos=%0d v_pos=%0d lk=%b, expected all 0",
        line_len, frame_lines, h_pos, v_pos, locked); end
    @(posedge pixel_clk);
    @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    drive_lines(5, 9, -1);
    drive_frames(2);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL midreset_not_yet: got %b expected 0", locked); end
    drive_frames(1);
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL midreset_relocked: got %b expected 1", locked); end
    total++; if (frame_lines !== 11'd10) begin bad++; $display("FAIL midreset_frame_lines: got %0d expected 10", frame_lines); end
  endtask

  initial begin
    sat_exp = W'(CNT_SAT_DEF);
    test_reset();
    test_basic();
    test_vga640();
    test_line_glitch();
    test_hsync_stop();
    test_coincident();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
